// File: rtl/encoder_pkg.sv
// encoder_pkg: shared FSM encoding and counter width for the 8-to-3 switch encoder
package encoder_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        FROZEN   = 2'd2,
        DISABLED = 2'd3
    } enc_state_t;

endpackage

// File: rtl/encoder8_3_sync_if.sv
// encoder8_3_sync_if: switch inputs and LED outputs of the 8-to-3 encoder
interface encoder8_3_sync_if;

    logic [7:0] Sw_I;
    logic       Sw_EI;
    logic       Sw_HOLD;
    logic [2:0] LED_Y;
    logic       LED_GS;
    logic       LED_EO;
    logic       LED_STB;

    modport master (
        output Sw_I, Sw_EI, Sw_HOLD,
        input  LED_Y, LED_GS, LED_EO, LED_STB
    );

    modport slave (
        input  Sw_I, Sw_EI, Sw_HOLD,
        output LED_Y, LED_GS, LED_EO, LED_STB
    );

endinterface

// File: rtl/debounce_vec.sv
// debounce_vec: two-flop synchronizer followed by whole-vector debounce.
// The accepted vector loads on the edge where the stability counter reaches
// its terminal count, so a vector stable for DEBOUNCE_CYCLES clocks is accepted
// DEBOUNCE_CYCLES clocks after it leaves the synchronizer.
module debounce_vec
    import encoder_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] accepted_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             changed;
    logic             load;

    // Synchronize the raw switches and keep last cycle's synchronized vector for change detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Restart the count on any change, otherwise count up and saturate at terminal count
    always_comb begin
        changed = (sync2_q != prev_q);
        cnt_d   = cnt_q;
        if (changed) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        load = !changed && (cnt_d == CNT_MAX);
    end

    // Stability counter and accepted vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            accepted_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (load) begin
                accepted_q <= sync2_q;
            end
        end
    end

    assign dout = accepted_q;

endmodule

// File: rtl/encoder8_3_sync.sv
// encoder8_3_sync: debounced 8-to-3 priority encoder with enable, hold/freeze
// and a strobe that marks every change of the registered LED outputs.
module encoder8_3_sync
    import encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    encoder8_3_sync_if.slave  bus
);

    logic [1:0] rst_sync_q;
    logic       rst_int_n;
    logic [1:0] ei_sync_q;
    logic [1:0] hold_sync_q;
    logic       ei_s;
    logic       hold_s;
    logic [7:0] acc_vec;
    logic [2:0] enc_idx;
    logic       any_active;

    enc_state_t state_q;
    enc_state_t next_state;
    logic [2:0] y_q, y_d;
    logic       gs_q, gs_d;
    logic       eo_q, eo_d;
    logic [4:0] prev_out_q;
    logic       stb_q;

    // Reset asserts immediately but releases only after two clean clock edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    // Enable and hold skip debounce but still need two-flop synchronization
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            ei_sync_q   <= 2'b00;
            hold_sync_q <= 2'b00;
        end else begin
            ei_sync_q   <= {ei_sync_q[0], bus.Sw_EI};
            hold_sync_q <= {hold_sync_q[0], bus.Sw_HOLD};
        end
    end

    assign ei_s   = ei_sync_q[1];
    assign hold_s = hold_sync_q[1];

    debounce_vec #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst_n (rst_int_n),
        .din   (bus.Sw_I),
        .dout  (acc_vec)
    );

    // Highest set bit of the accepted vector wins; zero vector gives index 0
    always_comb begin
        enc_idx    = 3'd0;
        any_active = |acc_vec;
        for (int i = 0; i < 8; i++) begin
            if (acc_vec[i]) begin
                enc_idx = 3'(i);
            end
        end
    end

    // Next state and next output values; enable low overrides everything
    always_comb begin
        next_state = state_q;
        y_d        = 3'd0;
        gs_d       = 1'b0;
        eo_d       = 1'b0;
        if (!ei_s) begin
            next_state = DISABLED;
        end else begin
            case (state_q)
                DISABLED, IDLE: next_state = any_active ? ACTIVE : IDLE;
                ACTIVE: begin
                    if (!any_active) begin
                        next_state = IDLE;
                    end else if (hold_s) begin
                        next_state = FROZEN;
                    end
                end
                FROZEN: begin
                    if (!hold_s) begin
                        next_state = any_active ? ACTIVE : IDLE;
                    end
                end
                default: next_state = DISABLED;
            endcase
        end
        case (next_state)
            IDLE: eo_d = 1'b1;
            ACTIVE: begin
                y_d  = enc_idx;
                gs_d = 1'b1;
            end
            FROZEN: begin
                y_d  = y_q;
                gs_d = gs_q;
                eo_d = eo_q;
            end
            default: ;
        endcase
    end

    // State and registered LED outputs
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= DISABLED;
            y_q     <= 3'd0;
            gs_q    <= 1'b0;
            eo_q    <= 1'b0;
        end else begin
            state_q <= next_state;
            y_q     <= y_d;
            gs_q    <= gs_d;
            eo_q    <= eo_d;
        end
    end

    // Strobe fires on the clock after the registered outputs differ from their previous value
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            prev_out_q <= 5'd0;
            stb_q      <= 1'b0;
        end else begin
            prev_out_q <= {y_q, gs_q, eo_q};
            stb_q      <= ({y_q, gs_q, eo_q} != prev_out_q);
        end
    end

    assign bus.LED_Y   = y_q;
    assign bus.LED_GS  = gs_q;
    assign bus.LED_EO  = eo_q;
    assign bus.LED_STB = stb_q;

endmodule

// File: doc/encoder8_3_sync.md
ENCODER8_3_SYNC -- requirements
Module: encoder8_3_sync

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, number of consecutive clocks a synchronized input vector must be unchanged before acceptance (legal range 2..65535).
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Sw_I  input  8  switch inputs, active-high, asynchronous to clk; bit 7 has highest priority.
REQ-005 Sw_EI  input  1  encoder enable, active-high, asynchronous to clk.
REQ-006 Sw_HOLD  input  1  freeze request, active-high, asynchronous to clk.
REQ-007 LED_Y  output  3  encoded index of highest-priority accepted active input.
REQ-008 LED_GS  output  1  group-select: high when enabled and any accepted input is active.
REQ-009 LED_EO  output  1  enable-out: high when enabled and no accepted input is active.
REQ-010 LED_STB  output  1  one-clock pulse whenever {LED_Y, LED_GS, LED_EO} changes value.

Function
REQ-011 Sw_I, Sw_EI and Sw_HOLD SHALL each pass through a 2-flop synchronizer before any other use.
REQ-012 Debounce SHALL apply to the synchronized 8-bit Sw_I vector as a whole: a 16-bit counter clears on any vector change and increments otherwise, saturating at DEBOUNCE_CYCLES-1.
REQ-013 The accepted vector SHALL load the synchronized vector on the clock where the counter equals DEBOUNCE_CYCLES-1 and the vector is unchanged.
REQ-014 A change lasting fewer than DEBOUNCE_CYCLES clocks SHALL never reach the accepted vector.
REQ-015 Priority encoding SHALL select the highest set bit index of the accepted vector; zero vector encodes index 0 with "none active".
REQ-016 Latency from a Sw_I change to registered outputs SHALL be exactly 2 + DEBOUNCE_CYCLES + 1 clocks for an input held stable throughout.
REQ-017 Sw_EI and Sw_HOLD SHALL bypass debounce; their effect on outputs SHALL appear 3 clocks after the input change.
REQ-018 FSM states: IDLE, ACTIVE, FROZEN, DISABLED.
REQ-019 DISABLED: entered from any state when synchronized EI is low; outputs Y=000, GS=0, EO=0; exits to IDLE or ACTIVE per accepted vector when EI returns high.
REQ-020 IDLE: accepted vector zero; outputs Y=000, GS=0, EO=1; goes to ACTIVE when accepted vector becomes nonzero.
REQ-021 ACTIVE: outputs Y=encoded index, GS=1, EO=0, updated each clock; goes to IDLE on zero vector; goes to FROZEN when synchronized HOLD is high.
REQ-022 FROZEN: outputs hold last ACTIVE values regardless of Sw_I; returns to ACTIVE or IDLE per current accepted vector when HOLD drops.
REQ-023 HOLD asserted in IDLE SHALL have no effect (no freeze of "none active").
REQ-024 EI low SHALL take priority over HOLD and over any simultaneous input change.
REQ-025 LED_STB SHALL pulse for exactly one clock, registered, on the clock after outputs change; no pulse while outputs are stable, including in FROZEN.
REQ-026 Debounce and accepted-vector logic SHALL keep running in DISABLED and FROZEN so exit reflects current inputs without re-debounce delay.

Reset
REQ-027 Asserting rst_n low SHALL immediately clear synchronizers, counter, accepted vector, FSM to DISABLED, and all outputs to 0 (LED_Y=000, LED_GS=0, LED_EO=0, LED_STB=0).
REQ-028 Reset assertion mid-debounce or in FROZEN SHALL discard all pending and held state; deassertion is synchronized to clk via a 2-flop reset release.
REQ-029 After reset release, the FSM SHALL stay in DISABLED until synchronized EI is high; no LED_STB pulse SHALL be generated by reset itself.

Structure
REQ-030 FSM state encoding and the 16-bit counter width constant SHALL live in a shared package encoder_pkg.
REQ-031 The synchronizer+debounce path SHALL be one sub-module, debounce_vec, parameterized by width and DEBOUNCE_CYCLES, reusable for other switch banks.
REQ-032 Priority encoder SHALL be combinational inside encoder8_3_sync; all outputs SHALL be registered.

Verification (DEBOUNCE_CYCLES=4)
REQ-033 Reset, EI=1, Sw_I=00000000 -> IDLE, LED_EO=1, LED_GS=0, one LED_STB pulse on EO rising.
REQ-034 Sw_I=00100100 held -> after exactly 7 clocks LED_Y=101, GS=1, EO=0, single STB pulse.
REQ-035 Sw_I glitch 00000000->10000000 for 3 clocks then back -> outputs unchanged, no STB.
REQ-036 ACTIVE at Y=101, HOLD=1, then Sw_I=00000010 -> Y stays 101; HOLD=0 -> Y=001 within 3 clocks, one STB.
REQ-037 EI=0 while FROZEN with Sw_I=11111111 -> DISABLED outputs all 0; EI=1 -> Y=111, GS=1, no re-debounce delay.
REQ-038 rst_n low mid-debounce (counter=2) -> all outputs 0 immediately, counter 0; release -> no STB until EI synchronized high.
